// File: rtl/uart_pkg.sv
// Shared definitions for the APB receive controller: register map, bit positions
// and the capture-FSM state encoding.
package uart_pkg;

    localparam logic [3:0] ADDR_CTRL   = 4'h0;
    localparam logic [3:0] ADDR_STATUS = 4'h4;
    localparam logic [3:0] ADDR_DATA   = 4'h8;
    localparam logic [3:0] ADDR_BAUD   = 4'hC;

    localparam int CTRL_RX_EN  = 0;
    localparam int CTRL_FLUSH  = 1;
    localparam int CTRL_IRQ_EN = 2;

    localparam int ST_NOT_EMPTY = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVERFLOW  = 2;
    localparam int ST_COUNT_LSB = 4;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2
    } cap_state_t;

    // Word index of a byte address; the two low address bits carry no meaning.
    function automatic logic [1:0] reg_index(input logic [3:0] addr);
        return addr[3:2];
    endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// APB slave bus bundle for the receive controller.
interface uart_rx_ctrl_if;

    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [3:0]  paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/uart_rx_ctrl_fifo.sv
// Synchronous receive FIFO; pointers wrap naturally, flush overrides push/pop.
module uart_rx_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_W     = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  logic                        pop,
    input  logic                        flush,
    input  logic [DATA_W-1:0]           wdata,
    output logic [DATA_W-1:0]           rdata,
    output logic [$clog2(FIFO_DEPTH):0] count,
    output logic                        full,
    output logic                        empty
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_do_push;
    logic              w_do_pop;

    assign empty = (r_count == '0);
    assign full  = (r_count == CNT_W'(FIFO_DEPTH));
    assign count = r_count;
    assign rdata = r_mem[r_rd_ptr];

    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !flush) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// APB-side receive controller: configures the receiver, captures each completed
// word into the receive FIFO and raises a level interrupt while data is pending.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_W     = 32,
    parameter int BAUD_RST   = 10416
) (
    input  logic              clk,
    input  logic              rst,
    uart_rx_ctrl_if.slave     bus,
    output logic              rx_enable,
    output logic [31:0]       baud_div,
    input  logic              rx_ready,
    input  logic [DATA_W-1:0] rx_data,
    output logic              irq
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    cap_state_t        r_state;
    logic              r_rx_ready_d;
    logic [DATA_W-1:0] r_cap_data;
    logic              r_rx_en;
    logic              r_irq_en;
    logic              r_overflow;
    logic [31:0]       r_baud;
    logic              r_irq;

    logic              w_access;
    logic              w_wr;
    logic              w_rd;
    logic [1:0]        w_idx;
    logic              w_rise;
    logic              w_push;
    logic              w_pop;
    logic              w_flush;
    logic              w_ovf_set;
    logic [DATA_W-1:0] w_fifo_rdata;
    logic [CNT_W-1:0]  w_count;
    logic              w_full;
    logic              w_empty;
    logic [31:0]       w_ctrl;
    logic [31:0]       w_status;
    logic [31:0]       w_prdata;
    logic              w_pslverr;
    logic              w_unused;

    assign w_access = bus.psel & bus.penable;
    assign w_wr     = w_access & bus.pwrite;
    assign w_rd     = w_access & ~bus.pwrite;
    assign w_idx    = reg_index(bus.paddr);
    assign w_unused = ^bus.paddr[1:0];

    assign w_rise    = rx_ready & ~r_rx_ready_d;
    assign w_push    = (r_state == S_CAPTURE);
    assign w_flush   = w_wr & (w_idx == reg_index(ADDR_CTRL)) & bus.pwdata[CTRL_FLUSH];
    assign w_ovf_set = w_push & w_full & ~w_pop;

    uart_rx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .DATA_W     (DATA_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .flush (w_flush),
        .wdata (r_cap_data),
        .rdata (w_fifo_rdata),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );

    // Capture FSM: one push per rising edge of rx_ready, however long it is held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_rx_ready_d <= 1'b0;
        end else begin
            r_rx_ready_d <= rx_ready;
            if (!r_rx_en) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE:    r_state <= S_ARMED;
                    S_ARMED:   r_state <= w_rise ? S_CAPTURE : S_ARMED;
                    S_CAPTURE: r_state <= S_ARMED;
                    default:   r_state <= S_IDLE;
                endcase
            end
        end
    end

    // rx_data is only valid with rx_ready, so hold it for the CAPTURE cycle.
    always_ff @(posedge clk) begin
        if (w_rise) begin
            r_cap_data <= rx_data;
        end
    end

    always_comb begin
        w_ctrl              = '0;
        w_ctrl[CTRL_RX_EN]  = r_rx_en;
        w_ctrl[CTRL_IRQ_EN] = r_irq_en;
    end

    always_comb begin
        w_status                         = '0;
        w_status[ST_NOT_EMPTY]           = ~w_empty;
        w_status[ST_FULL]                = w_full;
        w_status[ST_OVERFLOW]            = r_overflow;
        w_status[ST_COUNT_LSB +: CNT_W]  = w_count;
    end

    always_comb begin
        w_prdata  = '0;
        w_pslverr = 1'b0;
        w_pop     = 1'b0;
        if (w_rd) begin
            case (w_idx)
                reg_index(ADDR_CTRL):   w_prdata = w_ctrl;
                reg_index(ADDR_STATUS): w_prdata = w_status;
                reg_index(ADDR_DATA): begin
                    if (w_empty) begin
                        w_pslverr = 1'b1;
                    end else begin
                        w_prdata = 32'(w_fifo_rdata);
                        w_pop    = 1'b1;
                    end
                end
                default:                w_prdata = r_baud;
            endcase
        end else if (w_wr && (w_idx == reg_index(ADDR_BAUD)) && r_rx_en) begin
            w_pslverr = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_en    <= 1'b0;
            r_irq_en   <= 1'b0;
            r_baud     <= 32'(BAUD_RST);
            r_overflow <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            if (w_wr && (w_idx == reg_index(ADDR_CTRL))) begin
                r_rx_en  <= bus.pwdata[CTRL_RX_EN];
                r_irq_en <= bus.pwdata[CTRL_IRQ_EN];
            end
            if (w_wr && (w_idx == reg_index(ADDR_BAUD)) && !r_rx_en) begin
                r_baud <= bus.pwdata;
            end
            // Flush beats a fresh overflow; a fresh overflow beats a software clear.
            if (w_flush) begin
                r_overflow <= 1'b0;
            end else if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (w_wr && (w_idx == reg_index(ADDR_STATUS)) && bus.pwdata[ST_OVERFLOW]) begin
                r_overflow <= 1'b0;
            end
            r_irq <= r_irq_en & (~w_empty | r_overflow);
        end
    end

    assign bus.prdata  = w_prdata;
    assign bus.pslverr = w_pslverr;
    assign bus.pready  = 1'b1;
    assign rx_enable   = r_rx_en;
    assign baud_div    = r_baud;
    assign irq         = r_irq;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: captured words are queued when driven and
// compared as DATA reads drain the FIFO.
module tb_uart_rx_ctrl;
    import uart_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rx_enable;
    logic [31:0] baud_div;
    logic        rx_ready;
    logic [31:0] rx_data;
    logic        irq;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] sb[$];
    bit          m_ovf = 1'b0;

    always #5 clk = ~clk;

    uart_rx_ctrl_if bus ();

    uart_rx_ctrl #(
        .FIFO_DEPTH (DEPTH),
        .DATA_W     (32),
        .BAUD_RST   (10416)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .rx_enable (rx_enable),
        .baud_div  (baud_div),
        .rx_ready  (rx_ready),
        .rx_data   (rx_data),
        .irq       (irq)
    );

    function automatic logic [31:0] exp_status();
        logic [31:0] s;
        s      = '0;
        s[0]   = (sb.size() != 0);
        s[1]   = (sb.size() == DEPTH);
        s[2]   = m_ovf;
        s[6:4] = 3'(sb.size());
        return s;
    endfunction

    task automatic apb_write(input logic [3:0] a, input logic [31:0] d, output logic err);
        @(posedge clk); #1;
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1; bus.paddr = a; bus.pwdata = d;
        @(posedge clk); #1;
        bus.penable = 1'b1;
        @(negedge clk);
        err = bus.pslverr;
        @(posedge clk); #1;
        bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [3:0] a, output logic [31:0] d, output logic err);
        @(posedge clk); #1;
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = a;
        @(posedge clk); #1;
        bus.penable = 1'b1;
        @(negedge clk);
        d   = bus.prdata;
        err = bus.pslverr;
        @(posedge clk); #1;
        bus.psel = 1'b0; bus.penable = 1'b0;
    endtask

    // Drive one receiver word; the model records it only when capture is expected.
    task automatic send_word(input logic [31:0] d, input int hold, input bit enabled);
        @(posedge clk); #1;
        rx_data = d; rx_ready = 1'b1;
        if (enabled) begin
            if (sb.size() < DEPTH) sb.push_back(d);
            else m_ovf = 1'b1;
        end
        repeat (hold) @(posedge clk);
        #1 rx_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic        e;
        rst = 1'b0;
        #23 rst = 1'b1;
        #1;
        n_cmp++;
        if (rx_enable !== 1'b0 || irq !== 1'b0 || baud_div !== 32'd10416 || bus.prdata !== 32'd0 || bus.pslverr !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: rx_enable=%b irq=%b baud=%0d prdata=%h pslverr=%b, need 0 0 10416 0 0",
                     rx_enable, irq, baud_div, bus.prdata, bus.pslverr);
        end
        apb_read(ADDR_CTRL, d, e);
        n_cmp++;
        if (d !== 32'h0 || e !== 1'b0) begin n_err++; $display("FAIL reset_ctrl: got %h/%b need 0/0", d, e); end
        apb_read(ADDR_STATUS, d, e);
        n_cmp++;
        if (d !== 32'h0 || e !== 1'b0) begin n_err++; $display("FAIL reset_status: got %h/%b need 0/0", d, e); end
        apb_read(ADDR_DATA, d, e);
        n_cmp++;
        if (d !== 32'h0 || e !== 1'b1) begin n_err++; $display("FAIL reset_data_empty: got %h/%b need 0/1", d, e); end
        apb_read(ADDR_BAUD, d, e);
        n_cmp++;
        if (d !== 32'd10416 || e !== 1'b0) begin n_err++; $display("FAIL reset_baud: got %0d/%b need 10416/0", d, e); end
    endtask

    task automatic test_single();
        logic [31:0] d;
        logic [31:0] x;
        logic        e;
        apb_write(ADDR_CTRL, 32'h5, e);
        n_cmp++;
        if (rx_enable !== 1'b1 || e !== 1'b0) begin n_err++; $display("FAIL ctrl_enable: rx_enable=%b err=%b need 1/0", rx_enable, e); end
        send_word(32'hDEADBEEF, 1, 1'b1);
        n_cmp++;
        if (irq !== 1'b1) begin n_err++; $display("FAIL single_irq: got %b need 1", irq); end
        apb_read(ADDR_STATUS, d, e);
        n_cmp++;
        if (d !== 32'h011 || d !== exp_status()) begin n_err++; $display("FAIL single_status: got %h need %h", d, exp_status()); end
        apb_read(ADDR_DATA, d, e);
        x = sb.pop_front();
        n_cmp++;
        if (d !== x || e !== 1'b0) begin n_err++; $display("FAIL single_data: got %h/%b need %h/0", d, e, x); end
        apb_read(ADDR_STATUS, d, e);
        n_cmp++;
        if (d !== 32'h0 || irq !== 1'b0) begin n_err++; $display("FAIL single_drained: status %h irq %b need 0/0", d, irq); end
    endtask

    task automatic test_long_pulse();
        logic [31:0] d;
        logic [31:0] x;
        logic        e;
        send_word(32'h12345678, 20, 1'b1);
        apb_read(ADDR_STATUS, d, e);
        n_cmp++;
        if (d !== 32'h011) begin n_err++; $display("FAIL long_pulse_count: status %h need 011", d); end
        apb_read(ADDR_DATA, d, e);
        x = sb.pop_front();
        n_cmp++;
        if (d !== x || e !== 1'b0) begin n_err++; $display("FAIL long_pulse_data: got %h/%b need %h/0", d, e, x); end
        apb_read(ADDR_DATA, d, e);
        n_cmp++;
        if (d !== 32'h0 || e !== 1'b1) begin n_err++; $display("FAIL long_pulse_single_push: got %h/%b need 0/1", d, e); end
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        logic [31:0] x;
        logic        e;
        for (int i = 1; i <= 5; i++) send_word(32'(i), 1, 1'b1);
        apb_read(ADDR_STATUS, d, e);
        n_cmp++;
        if (d !== 32'h047 || d !== exp_status() || irq !== 1'b1) begin
            n_err++; $display("FAIL overflow_status: got %h irq %b need 047 irq 1", d, irq);
        end
        for (int i = 0; i < DEPTH; i++) begin
            apb_read(ADDR_DATA, d, e);
            x = sb.pop_front();
            n_cmp++;
            if (d !== x || e !== 1'b0) begin n_err++; $display("FAIL overflow_data%0d: got %h/%b need %h/0", i, d, e, x); end
        end
        apb_read(ADDR_STATUS, d, e);
        n_cmp++;
        if (d !== 32'h004) begin n_err++; $display("FAIL overflow_sticky: status %h need 004", d); end
        apb_write(ADDR_STATUS, 32'h4, e);
        m_ovf = 1'b0;
        apb_read(ADDR_STATUS, d, e);
        n_cmp++;
        if (d !== exp_status() || d !== 32'h0) begin n_err++; $display("FAIL overflow_clear: status %h need 0", d); end
    endtask

    task automatic test_flush_and_pop_push();
        logic [31:0] d;
        logic [31:0] x;
        logic        e;
        send_word(32'hF0, 1, 1'b1);
        send_word(32'hF1, 1, 1'b1);
        apb_write(ADDR_CTRL, 32'h7, e);
        sb.delete();
        m_ovf = 1'b0;
        apb_read(ADDR_STATUS, d, e);
        n_cmp++;
        if (d !== 32'h0 || irq !== 1'b0) begin n_err++; $display("FAIL flush: status %h irq %b need 0/0", d, irq); end
        for (int i = 0; i < DEPTH; i++) send_word(32'h10 + 32'(i), 1, 1'b1);
        // DATA pop and the capture push of 0xA5 land in the same cycle.
        @(posedge clk); #1;
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = ADDR_DATA;
        rx_data = 32'hA5; rx_ready = 1'b1;
        @(posedge clk); #1;
        bus.penable = 1'b1; rx_ready = 1'b0;
        @(negedge clk);
        d = bus.prdata; e = bus.pslverr;
        @(posedge clk); #1;
        bus.psel = 1'b0; bus.penable = 1'b0;
        x = sb.pop_front();
        sb.push_back(32'hA5);
        n_cmp++;
        if (d !== x || e !== 1'b0) begin n_err++; $display("FAIL poppush_data: got %h/%b need %h/0", d, e, x); end
        apb_read(ADDR_STATUS, d, e);
        n_cmp++;
        if (d !== 32'h043 || d !== exp_status()) begin n_err++; $display("FAIL poppush_status: got %h need 043", d); end
        for (int i = 0; i < DEPTH; i++) begin
            apb_read(ADDR_DATA, d, e);
            x = sb.pop_front();
            n_cmp++;
            if (d !== x || e !== 1'b0) begin n_err++; $display("FAIL poppush_drain%0d: got %h/%b need %h/0", i, d, e, x); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        logic [31:0] x;
        logic        e;
        apb_write(ADDR_CTRL, 32'h1, e);
        for (int i = 0; i < 3; i++) send_word(32'hC0DE0000 + 32'(i), 1, 1'b1);
        apb_write(ADDR_DATA, 32'hFFFF_FFFF, e);
        n_cmp++;
        if (e !== 1'b0) begin n_err++; $display("FAIL data_write_err: got %b need 0", e); end
        apb_read(ADDR_STATUS, d, e);
        n_cmp++;
        if (d !== exp_status() || d !== 32'h031) begin n_err++; $display("FAIL b2b_status: got %h need %h", d, exp_status()); end
        while (sb.size() != 0) begin
            apb_read(ADDR_DATA, d, e);
            x = sb.pop_front();
            n_cmp++;
            if (d !== x || e !== 1'b0) begin n_err++; $display("FAIL b2b_data: got %h/%b need %h/0", d, e, x); end
        end
    endtask

    task automatic test_baud();
        logic [31:0] d;
        logic        e;
        apb_write(ADDR_BAUD, 32'h1B2, e);
        n_cmp++;
        if (e !== 1'b1 || baud_div !== 32'd10416) begin n_err++; $display("FAIL baud_locked: err %b baud %h need 1/28b0", e, baud_div); end
        apb_write(ADDR_CTRL, 32'h0, e);
        n_cmp++;
        if (rx_enable !== 1'b0) begin n_err++; $display("FAIL ctrl_disable: rx_enable %b need 0", rx_enable); end
        apb_write(ADDR_BAUD, 32'h1B2, e);
        n_cmp++;
        if (e !== 1'b0 || baud_div !== 32'h1B2) begin n_err++; $display("FAIL baud_write: err %b baud %h need 0/1b2", e, baud_div); end
        apb_read(ADDR_BAUD, d, e);
        n_cmp++;
        if (d !== 32'h1B2) begin n_err++; $display("FAIL baud_read: got %h need 1b2", d); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic        e;
        apb_write(ADDR_CTRL, 32'h1, e);
        send_word(32'hAAAA0001, 1, 1'b1);
        send_word(32'hAAAA0002, 1, 1'b1);
        apb_read(ADDR_STATUS, d, e);
        n_cmp++;
        if (d !== 32'h021) begin n_err++; $display("FAIL pre_reset_status: got %h need 021", d); end
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        n_cmp++;
        if (dut.r_state !== S_IDLE || dut.u_fifo.r_count !== '0 || rx_enable !== 1'b0 || baud_div !== 32'd10416) begin
            n_err++;
            $display("FAIL async_reset: state %0d count %0d rx_enable %b baud %h need 0 0 0 28b0",
                     dut.r_state, dut.u_fifo.r_count, rx_enable, baud_div);
        end
        #10 rst = 1'b1;
        sb.delete();
        m_ovf = 1'b0;
        send_word(32'hBAD0BAD0, 1, 1'b0);
        apb_read(ADDR_STATUS, d, e);
        n_cmp++;
        if (d !== 32'h0 || irq !== 1'b0) begin n_err++; $display("FAIL post_reset_idle: status %h irq %b need 0/0", d, irq); end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b0;
        bus.paddr   = 4'h0;
        bus.pwdata  = 32'h0;
        rx_ready    = 1'b0;
        rx_data     = 32'h0;
        test_reset();
        test_single();
        test_long_pulse();
        test_overflow();
        test_flush_and_pop_push();
        test_back_to_back();
        test_baud();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
